// File: rtl/decode_stage_pipe.sv
// MIPS-subset decode stage: register file with write-through bypass, control
// decode, sign extension, load-use hazard detection and the ID/EX register.
module decode_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  output logic              id_ready,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [AW-1:0]     ex_rs,
  output logic [AW-1:0]     ex_rt,
  output logic [AW-1:0]     ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic              ex_branch,
  output logic [2:0]        ex_alu_op,
  output logic              ex_illegal
);

  logic [DATA_W-1:0] r_regs [NREG];

  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [AW-1:0]     w_rs;
  logic [AW-1:0]     w_rt;
  logic [AW-1:0]     w_rd;
  logic [AW-1:0]     w_dest;
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;
  logic [DATA_W-1:0] w_imm;
  logic              w_reg_write;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_mem_to_reg;
  logic              w_alu_src;
  logic              w_branch;
  logic              w_illegal;
  logic [2:0]        w_alu_op;
  logic              w_adv;
  logic              w_hazard;
  logic              w_clear;

  assign w_op    = if_instr[31:26];
  assign w_funct = if_instr[5:0];
  assign w_rs    = if_instr[21 +: AW];
  assign w_rt    = if_instr[16 +: AW];
  assign w_rd    = if_instr[11 +: AW];
  assign w_imm   = DATA_W'($signed(if_instr[15:0]));

  // A write landing this cycle is forwarded so decode never sees stale data.
  assign w_rs_data = (w_rs == {AW{1'b0}}) ? {DATA_W{1'b0}} :
                     (wb_en && (wb_addr == w_rs)) ? wb_data : r_regs[w_rs];
  assign w_rt_data = (w_rt == {AW{1'b0}}) ? {DATA_W{1'b0}} :
                     (wb_en && (wb_addr == w_rt)) ? wb_data : r_regs[w_rt];

  assign w_adv    = ex_ready || !ex_valid;
  assign w_hazard = ex_valid && ex_mem_read && (ex_dest != {AW{1'b0}}) &&
                    ((ex_dest == w_rs) || (ex_dest == w_rt)) && if_valid;
  assign id_ready = !rst && (flush || (w_adv && !w_hazard));
  assign w_clear  = rst || flush || (w_adv && w_hazard);

  // Control decode of the instruction currently offered by fetch.
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src    = 1'b0;
    w_branch     = 1'b0;
    w_illegal    = 1'b0;
    w_alu_op     = 3'b000;
    w_dest       = w_rt;
    case (w_op)
      6'h00: begin
        w_dest = w_rd;
        case (w_funct)
          6'h20: begin w_alu_op = 3'b010; w_reg_write = 1'b1; end
          6'h22: begin w_alu_op = 3'b110; w_reg_write = 1'b1; end
          6'h24: begin w_alu_op = 3'b000; w_reg_write = 1'b1; end
          6'h25: begin w_alu_op = 3'b001; w_reg_write = 1'b1; end
          6'h2A: begin w_alu_op = 3'b111; w_reg_write = 1'b1; end
          default: w_illegal = 1'b1;
        endcase
      end
      6'h23: begin
        w_alu_op     = 3'b010;
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      6'h2B: begin
        w_alu_op    = 3'b010;
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      6'h04: begin
        w_alu_op = 3'b110;
        w_branch = 1'b1;
      end
      6'h08: begin
        w_alu_op    = 3'b010;
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Register file write port; runs independently of stall and flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (wb_en && (wb_addr != {AW{1'b0}})) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // ID/EX register: reset, flush and load-use bubbles all empty it.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      ex_valid      <= 1'b0;
      ex_rs_data    <= {DATA_W{1'b0}};
      ex_rt_data    <= {DATA_W{1'b0}};
      ex_imm        <= {DATA_W{1'b0}};
      ex_rs         <= {AW{1'b0}};
      ex_rt         <= {AW{1'b0}};
      ex_dest       <= {AW{1'b0}};
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= 3'b000;
      ex_illegal    <= 1'b0;
    end else if (w_adv) begin
      ex_valid      <= if_valid;
      ex_rs_data    <= w_rs_data;
      ex_rt_data    <= w_rt_data;
      ex_imm        <= w_imm;
      ex_rs         <= w_rs;
      ex_rt         <= w_rt;
      ex_dest       <= w_dest;
      ex_reg_write  <= w_reg_write  && if_valid;
      ex_mem_read   <= w_mem_read   && if_valid;
      ex_mem_write  <= w_mem_write  && if_valid;
      ex_mem_to_reg <= w_mem_to_reg && if_valid;
      ex_alu_src    <= w_alu_src    && if_valid;
      ex_branch     <= w_branch     && if_valid;
      ex_alu_op     <= if_valid ? w_alu_op : 3'b000;
      ex_illegal    <= w_illegal    && if_valid;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: a 32x32 instance driven through the
// main scenarios and a 16x16 instance for the narrow-parameter variant.
module tb_decode_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_valid, flush, ex_ready, wb_en;
  logic [31:0] if_instr, wb_data;
  logic [4:0]  wb_addr;
  logic        id_ready, ex_valid;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_alu_src, ex_branch, ex_illegal;
  logic [2:0]  ex_alu_op;

  logic        s_if_valid, s_flush, s_ex_ready, s_wb_en;
  logic [31:0] s_if_instr;
  logic [15:0] s_wb_data;
  logic [3:0]  s_wb_addr;
  logic        s_id_ready, s_ex_valid;
  logic [15:0] s_ex_rs_data, s_ex_rt_data, s_ex_imm;
  logic [3:0]  s_ex_rs, s_ex_rt, s_ex_dest;
  logic        s_ex_reg_write, s_ex_mem_read, s_ex_mem_write, s_ex_mem_to_reg;
  logic        s_ex_alu_src, s_ex_branch, s_ex_illegal;
  logic [2:0]  s_ex_alu_op;

  decode_stage_pipe #(.DATA_W(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_alu_op(ex_alu_op), .ex_illegal(ex_illegal)
  );

  decode_stage_pipe #(.DATA_W(16), .NREG(16)) dut16 (
    .clk(clk), .rst(rst), .if_valid(s_if_valid), .if_instr(s_if_instr),
    .id_ready(s_id_ready), .flush(s_flush), .ex_ready(s_ex_ready),
    .wb_en(s_wb_en), .wb_addr(s_wb_addr), .wb_data(s_wb_data),
    .ex_valid(s_ex_valid), .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data),
    .ex_imm(s_ex_imm), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_dest(s_ex_dest),
    .ex_reg_write(s_ex_reg_write), .ex_mem_read(s_ex_mem_read),
    .ex_mem_write(s_ex_mem_write), .ex_mem_to_reg(s_ex_mem_to_reg),
    .ex_alu_src(s_ex_alu_src), .ex_branch(s_ex_branch),
    .ex_alu_op(s_ex_alu_op), .ex_illegal(s_ex_illegal)
  );

  // ctrl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, illegal}
  typedef struct packed {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [6:0]  ctrl;
    logic [2:0]  alu;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_regs [32];
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference register file, written on the same edge as the design.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      m_regs[wb_addr] <= wb_data;
    end
  end

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_en && (wb_addr == a)) return wb_data;
    return m_regs[a];
  endfunction

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    e.rs      = ins[25:21];
    e.rt      = ins[20:16];
    e.rs_data = rd_model(ins[25:21]);
    e.rt_data = rd_model(ins[20:16]);
    e.imm     = {{16{ins[15]}}, ins[15:0]};
    e.dest    = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20:   {e.ctrl, e.alu} = {7'b1000000, 3'b010};
          6'h22:   {e.ctrl, e.alu} = {7'b1000000, 3'b110};
          6'h24:   {e.ctrl, e.alu} = {7'b1000000, 3'b000};
          6'h25:   {e.ctrl, e.alu} = {7'b1000000, 3'b001};
          6'h2A:   {e.ctrl, e.alu} = {7'b1000000, 3'b111};
          default: {e.ctrl, e.alu} = {7'b0000001, 3'b000};
        endcase
      end
      6'h23:   {e.ctrl, e.alu} = {7'b1101100, 3'b010};
      6'h2B:   {e.ctrl, e.alu} = {7'b0010100, 3'b010};
      6'h04:   {e.ctrl, e.alu} = {7'b0000010, 3'b110};
      6'h08:   {e.ctrl, e.alu} = {7'b1000100, 3'b010};
      default: {e.ctrl, e.alu} = {7'b0000001, 3'b000};
    endcase
    return e;
  endfunction

  // Scoreboard: every entry execute consumes must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ex_valid && ex_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {32'h0, if_instr}, 64'h0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rs_data", ex_rs_data, e.rs_data);
        chk("rt_data", ex_rt_data, e.rt_data);
        chk("imm", ex_imm, e.imm);
        chk("rs", ex_rs, e.rs);
        chk("rt", ex_rt, e.rt);
        if (!e.ctrl[0]) chk("dest", ex_dest, e.dest);
        chk("ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                     ex_alu_src, ex_branch, ex_illegal}, e.ctrl);
        chk("alu_op", ex_alu_op, e.alu);
      end
    end
  end

  task automatic issue(input logic [31:0] ins);
    int n;
    n = 0;
    if_valid = 1'b1;
    if_instr = ins;
    @(negedge clk);
    while (!id_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", id_ready, 1'b1);
    if (id_ready) q.push_back(model(ins));
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; flush = 1'b0;
    ex_ready = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    s_if_valid = 1'b0; s_if_instr = 32'h0; s_flush = 1'b0; s_ex_ready = 1'b1;
    s_wb_en = 1'b0; s_wb_addr = 4'd0; s_wb_data = 16'h0;

    @(negedge clk);
    chk("rst_ready", id_ready, 1'b0);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_fields", {ex_rs_data, ex_alu_op, ex_dest, ex_reg_write}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // r5 = 0x1234, then add r3,r5,r0
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
    @(posedge clk); #1;
    wb_en = 1'b0;
    issue(32'h00A01820);

    // same-cycle write bypass: r7 = 0xDEAD while add r1,r7,r0 decodes
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD;
    issue(32'h00E00820);
    // writes to r0 are dropped
    wb_addr = 5'd0; wb_data = 32'hFFFF;
    issue(32'h00001020);
    wb_en = 1'b0;
    issue(32'h00001020);

    // load-use: lw r2,-4(r1) then add r4,r2,r2
    issue(32'h8C22FFFC);
    if_valid = 1'b1; if_instr = 32'h00422020;
    @(negedge clk);
    chk("hazard_ready", id_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bubble_valid", ex_valid, 1'b0);
    chk("bubble_ctrl", {ex_reg_write, ex_mem_read, ex_mem_to_reg}, 3'b000);
    chk("bubble_ready", id_ready, 1'b1);
    q.push_back(model(32'h00422020));
    @(posedge clk); #1;
    if_valid = 1'b0;

    // back-pressure on sub r6,r5,r5 with or r8,r5,r7 waiting
    issue(32'h00A53022);
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = 32'h00A74025;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", id_ready, 1'b0);
      chk("stall_valid", ex_valid, 1'b1);
      chk("stall_rs_data", ex_rs_data, q[0].rs_data);
      chk("stall_dest", ex_dest, q[0].dest);
      chk("stall_alu", ex_alu_op, q[0].alu);
      @(posedge clk); #1;
    end
    ex_ready = 1'b1;
    issue(32'h00A74025);
    @(negedge clk);
    chk("release_valid", ex_valid, 1'b1);
    @(posedge clk); #1;

    // flush with live ID/EX and a valid fetch word
    issue(32'h20A90007);
    ex_ready = 1'b0; flush = 1'b1; if_valid = 1'b1; if_instr = 32'h00A01820;
    @(negedge clk);
    chk("flush_ready", id_ready, 1'b1);
    chk("flush_pre_valid", ex_valid, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    void'(q.pop_front());
    @(negedge clk);
    chk("flush_valid", ex_valid, 1'b0);
    @(posedge clk); #1;

    // flush beats a simultaneous load-use hazard
    issue(32'h8C22FFFC);
    ex_ready = 1'b0; flush = 1'b1; if_valid = 1'b1; if_instr = 32'h00422020;
    @(negedge clk);
    chk("flush_hz_ready", id_ready, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    void'(q.pop_front());
    @(negedge clk);
    chk("flush_hz_valid", ex_valid, 1'b0);
    @(posedge clk); #1;

    // remaining opcodes and illegal encodings
    issue(32'hAC250008);
    issue(32'h10A6FFFF);
    issue(32'h00A75024);
    issue(32'h00A7582A);
    issue(32'hFC000000);
    issue(32'h00000003);

    // reset while stalled drops the held entry and clears the register file
    issue(32'h00A01820);
    ex_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_stall_ready", id_ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; ex_ready = 1'b1;
    void'(q.pop_front());
    @(negedge clk);
    chk("rst_stall_valid", ex_valid, 1'b0);
    @(posedge clk); #1;
    issue(32'h00A01820);

    // narrow instance: rs field 0x15 truncates to r5, imm not extended
    s_wb_en = 1'b1; s_wb_addr = 4'd5; s_wb_data = 16'hBEEF;
    @(posedge clk); #1;
    s_wb_en = 1'b0; s_if_valid = 1'b1; s_if_instr = 32'h22A38001;
    @(negedge clk);
    chk("n16_ready", s_id_ready, 1'b1);
    @(posedge clk); #1;
    s_if_valid = 1'b0;
    @(negedge clk);
    chk("n16_valid", s_ex_valid, 1'b1);
    chk("n16_rs_data", s_ex_rs_data, 16'hBEEF);
    chk("n16_imm", s_ex_imm, 16'h8001);
    chk("n16_rs", s_ex_rs, 4'd5);
    chk("n16_dest", s_ex_dest, 4'd3);
    chk("n16_ctrl", {s_ex_reg_write, s_ex_alu_src, s_ex_illegal, s_ex_alu_op}, 6'b110010);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
